gray_seq_ctrl: RTL and testbench



---
 rtl/gray_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_gray_seq_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl
// Command-driven sequencer for a WIDTH-bit Gray-code counter.
// A command (direction, step count, optional binary preload) is taken over a
// valid/ready handshake while idle. The counter then advances one step per
// cycle with hold low. wrap pulses after a wrapping step, and done pulses
// once when the command completes.
//
// Ports:
//   clk          system clock, rising edge
//   rstn         asynchronous active-low reset
//   cmd_valid    command present
//   cmd_ready    command can be accepted (IDLE only)
//   cmd_dir      0 = count up, 1 = count down
//   cmd_steps    number of steps to perform (0 allowed)
//   cmd_load     preload the counter with cmd_load_val at acceptance
//   cmd_load_val preload value, binary
//   hold         freeze stepping while high (RUN only)
//   gray_out     registered Gray code of the current count
//   bin_out      registered binary count
//   busy         high in RUN and DONE
//   done         one-cycle completion pulse
//   wrap         one-cycle pulse after a wrapping step
module gray_seq_ctrl #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_load,
  input  logic [WIDTH-1:0] cmd_load_val,
  input  logic             hold,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] BIN_ONE = WIDTH'(1);
  localparam logic [CNT_W-1:0] REM_ONE = CNT_W'(1);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   bin_reg, bin_next;
  logic [WIDTH-1:0]   gray_reg, gray_next;
  logic [CNT_W-1:0]   rem_reg, rem_next;
  logic               dir_reg, dir_next;
  logic               wrap_reg, wrap_next;

  // Next-state and datapath logic.
  always_comb begin
    state_next = state_reg;
    bin_next   = bin_reg;
    rem_next   = rem_reg;
    dir_next   = dir_reg;
    wrap_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          dir_next = cmd_dir;
          rem_next = cmd_steps;
          if (cmd_load) begin
            bin_next = cmd_load_val;
          end
          state_next = (cmd_steps != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (!hold) begin
          if (dir_reg) begin
            bin_next  = bin_reg - BIN_ONE;
            wrap_next = (bin_reg == '0);
          end else begin
            bin_next  = bin_reg + BIN_ONE;
            wrap_next = &bin_reg;
          end
          rem_next = rem_reg - REM_ONE;
          // The step that consumes the last count finishes the command.
          if (rem_reg == REM_ONE) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // The Gray code is encoded from the next binary value so that both
  // registers change on the same edge and gray_out stays a register.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
      assign gray_next[gi] = bin_next[gi] ^ bin_next[gi+1];
    end
  endgenerate
  assign gray_next[WIDTH-1] = bin_next[WIDTH-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
      bin_reg   <= '0;
      gray_reg  <= '0;
      rem_reg   <= '0;
      dir_reg   <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      bin_reg   <= bin_next;
      gray_reg  <= gray_next;
      rem_reg   <= rem_next;
      dir_reg   <= dir_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign cmd_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign wrap      = wrap_reg;
  assign bin_out   = bin_reg;
  assign gray_out  = gray_reg;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl
// Directed bench for gray_seq_ctrl (WIDTH=3, CNT_W=8). Inputs change 1 time
// unit after a rising edge, and outputs are sampled at that point.
module tb_gray_seq_ctrl;

  localparam int WIDTH = 3;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rstn;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic             cmd_load;
  logic [WIDTH-1:0] cmd_load_val;
  logic             hold;
  logic [WIDTH-1:0] gray_out;
  logic [WIDTH-1:0] bin_out;
  logic             busy;
  logic             done;
  logic             wrap;

  int checks   = 0;
  int failures = 0;

  gray_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_dir      (cmd_dir),
    .cmd_steps    (cmd_steps),
    .cmd_load     (cmd_load),
    .cmd_load_val (cmd_load_val),
    .hold         (hold),
    .gray_out     (gray_out),
    .bin_out      (bin_out),
    .busy         (busy),
    .done         (done),
    .wrap         (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for exactly one accept edge.
  task automatic send_cmd(input logic dir, input int steps, input logic load, input int val);
    cmd_valid    = 1'b1;
    cmd_dir      = dir;
    cmd_steps    = CNT_W'(steps);
    cmd_load     = load;
    cmd_load_val = WIDTH'(val);
    tick();
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    $display("cmd dir=%0d steps=%0d load=%0d val=%0d -> gray=%b bin=%0d", dir, steps, load, val, gray_out, bin_out);
  endtask

  logic [WIDTH-1:0] up_gray [8];

  initial begin
    up_gray = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    rstn = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0;
    cmd_load = 1'b0; cmd_load_val = '0; hold = 1'b0;

    // Reset state, with a command offered that must not be taken.
    #2;
    cmd_valid = 1'b1; cmd_steps = 8'd3;
    tick();
    check_eq("rst_gray", gray_out, 0);
    check_eq("rst_bin", bin_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_wrap", wrap, 0);
    check_eq("rst_ready", cmd_ready, 1);
    cmd_valid = 1'b0;
    rstn = 1'b1;
    tick();
    check_eq("rst_rel_busy", busy, 0);

    // 1. Up, full cycle.
    send_cmd(1'b0, 8, 1'b0, 0);
    check_eq("up_e0_gray", gray_out, 0);
    check_eq("up_e0_ready", cmd_ready, 0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      $display("up step E%0d gray=%b wrap=%0d done=%0d", i, gray_out, wrap, done);
      check_eq($sformatf("up_e%0d_gray", i), gray_out, up_gray[i-1]);
      check_eq($sformatf("up_e%0d_wrap", i), wrap, (i == 8));
      check_eq($sformatf("up_e%0d_done", i), done, (i == 8));
      check_eq($sformatf("up_e%0d_ready", i), cmd_ready, 0);
    end
    tick();
    check_eq("up_e9_done", done, 0);
    check_eq("up_e9_wrap", wrap, 0);
    check_eq("up_e9_ready", cmd_ready, 1);
    check_eq("up_e9_busy", busy, 0);

    // 2. Down with preload of 0, one step wraps to 7.
    send_cmd(1'b1, 1, 1'b1, 0);
    check_eq("dn_e0_gray", gray_out, 0);
    check_eq("dn_e0_busy", busy, 1);
    check_eq("dn_e0_wrap", wrap, 0);
    tick();
    check_eq("dn_e1_bin", bin_out, 7);
    check_eq("dn_e1_gray", gray_out, 3'b100);
    check_eq("dn_e1_wrap", wrap, 1);
    check_eq("dn_e1_done", done, 1);
    tick();
    check_eq("dn_e2_ready", cmd_ready, 1);

    // 3. Zero-step preload of 5.
    send_cmd(1'b0, 0, 1'b1, 5);
    check_eq("z_e0_gray", gray_out, 3'b111);
    check_eq("z_e0_bin", bin_out, 5);
    check_eq("z_e0_done", done, 1);
    check_eq("z_e0_wrap", wrap, 0);
    tick();
    check_eq("z_e1_done", done, 0);
    check_eq("z_e1_bin", bin_out, 5);
    check_eq("z_e1_wrap", wrap, 0);
    check_eq("z_e1_ready", cmd_ready, 1);

    // 4. Hold for three cycles after E2.
    send_cmd(1'b0, 4, 1'b1, 0);
    tick();
    check_eq("h_e1_gray", gray_out, 3'b001);
    tick();
    check_eq("h_e2_gray", gray_out, 3'b011);
    hold = 1'b1;
    for (int i = 3; i <= 5; i++) begin
      tick();
      check_eq($sformatf("h_e%0d_gray", i), gray_out, 3'b011);
      check_eq($sformatf("h_e%0d_done", i), done, 0);
    end
    hold = 1'b0;
    tick();
    check_eq("h_e6_gray", gray_out, 3'b010);
    check_eq("h_e6_done", done, 0);
    tick();
    check_eq("h_e7_gray", gray_out, 3'b110);
    check_eq("h_e7_done", done, 1);
    tick();
    check_eq("h_e8_done", done, 0);

    // 5. Command offered during RUN is ignored, then reset mid-RUN at count 3.
    send_cmd(1'b0, 5, 1'b1, 0);
    cmd_valid = 1'b1; cmd_steps = 8'd2; cmd_dir = 1'b1;
    tick();
    check_eq("ig_e1_bin", bin_out, 1);
    tick();
    check_eq("ig_e2_bin", bin_out, 2);
    cmd_valid = 1'b0;
    tick();
    check_eq("ig_e3_bin", bin_out, 3);
    check_eq("ig_e3_done", done, 0);
    check_eq("ig_e3_busy", busy, 1);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("ar_gray", gray_out, 0);
    check_eq("ar_bin", bin_out, 0);
    check_eq("ar_busy", busy, 0);
    check_eq("ar_done", done, 0);
    check_eq("ar_wrap", wrap, 0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("ar_post%0d_done", i), done, 0);
      check_eq($sformatf("ar_post%0d_busy", i), busy, 0);
    end
    send_cmd(1'b0, 2, 1'b0, 0);
    tick();
    check_eq("nx_e1_gray", gray_out, 3'b001);
    tick();
    check_eq("nx_e2_gray", gray_out, 3'b011);
    check_eq("nx_e2_done", done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
